// File: rtl/uart_fifo.sv
// Memory-mapped UART: configurable framing, independent TX/RX FIFOs,
// sticky W1C error flags and a registered level interrupt.
module uart_fifo #(
    parameter int          DATA_BITS  = 8,
    parameter int          TX_DEPTH   = 8,
    parameter int          RX_DEPTH   = 8,
    parameter logic [15:0] BAUD_RESET = 16'h01B8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic        re_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        irq_o,
    output logic        tx_pin,
    input  logic        rx_pin
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [3:0]   LAST_BIT    = 4'(DATA_BITS - 1);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW + 1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW + 1)'(RX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    logic [7:0] reg_a;
    logic       wr_ctrl, wr_stat, wr_baud, wr_txd, rd_rxd;
    logic       unused_bits;

    assign reg_a       = addr_i[7:0];
    assign wr_ctrl     = we_i && (reg_a == 8'h00);
    assign wr_stat     = we_i && (reg_a == 8'h04);
    assign wr_baud     = we_i && (reg_a == 8'h08);
    assign wr_txd      = we_i && (reg_a == 8'h0C);
    assign rd_rxd      = re_i && (reg_a == 8'h10);
    assign unused_bits = ^{addr_i[31:8], data_i[31:16]};

    logic [6:0]  ctrl_q;
    logic [15:0] baud_q;
    logic        perr_q, ferr_q, ovr_q, irq_q;
    logic        set_perr, set_ferr, set_ovr;

    // ---------------- FIFOs ----------------
    logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
    logic [TAW-1:0]       tx_wp_q, tx_rp_q;
    logic [TAW:0]         tx_cnt_q;
    logic                 tx_full, tx_empty, tx_push, tx_pop;

    logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
    logic [RAW-1:0]       rx_wp_q, rx_rp_q;
    logic [RAW:0]         rx_cnt_q;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

    assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign tx_push  = wr_txd && ctrl_q[0] && (!tx_full || tx_pop);
    assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_pop   = rd_rxd && !rx_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
            for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wp_q] <= data_i[DATA_BITS-1:0];
                tx_wp_q         <= tx_wp_q + TAW'(1);
            end
            if (tx_pop) tx_rp_q <= tx_rp_q + TAW'(1);
            tx_cnt_q <= tx_cnt_q + (TAW + 1)'(tx_push) - (TAW + 1)'(tx_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
            for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wp_q] <= rx_sh_d;
                rx_wp_q         <= rx_wp_q + RAW'(1);
            end
            if (rx_pop) rx_rp_q <= rx_rp_q + RAW'(1);
            rx_cnt_q <= rx_cnt_q + (RAW + 1)'(rx_push) - (RAW + 1)'(rx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    state_e               tx_st_q, tx_st_d;
    logic [15:0]          tx_tmr_q, tx_tmr_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, tx_head;
    logic                 tx_par_q, tx_par_d, tx_pen_q, tx_pen_d;
    logic                 tx_stop2_q, tx_stop2_d, tx_stopn_q, tx_stopn_d;
    logic                 tx_q, tx_d, tx_go, tx_start, tx_bit_end, tx_busy;

    assign tx_head    = tx_mem[tx_rp_q];
    assign tx_go      = ctrl_q[0] && !tx_empty;
    assign tx_bit_end = (tx_tmr_q == baud_q);
    assign tx_busy    = (tx_st_q != S_IDLE) || !tx_empty;
    assign tx_pop     = tx_start;

    always_comb begin
        tx_st_d    = tx_st_q;
        tx_tmr_d   = tx_bit_end ? 16'd0 : tx_tmr_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
        tx_stop2_d = tx_stop2_q;
        tx_stopn_d = tx_stopn_q;
        tx_start   = 1'b0;
        case (tx_st_q)
            S_IDLE: begin
                tx_tmr_d = '0;
                tx_start = tx_go;
            end
            S_START: if (tx_bit_end) begin
                tx_st_d  = S_DATA;
                tx_bit_d = '0;
            end
            S_DATA: if (tx_bit_end) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == LAST_BIT) tx_st_d = tx_pen_q ? S_PAR : S_STOP;
            end
            S_PAR: if (tx_bit_end) tx_st_d = S_STOP;
            S_STOP: if (tx_bit_end) begin
                if (tx_stop2_q && !tx_stopn_q) tx_stopn_d = 1'b1;
                else if (tx_go)                tx_start   = 1'b1;
                else                           tx_st_d    = S_IDLE;
            end
            default: tx_st_d = S_IDLE;
        endcase
        // Framing is captured per character so CTRL writes never split a frame.
        if (tx_start) begin
            tx_st_d    = S_START;
            tx_tmr_d   = '0;
            tx_sh_d    = tx_head;
            tx_pen_d   = ^ctrl_q[3:2];
            tx_par_d   = (^tx_head) ^ ctrl_q[3];
            tx_stop2_d = ctrl_q[4];
            tx_stopn_d = 1'b0;
        end
        case (tx_st_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = tx_sh_d[0];
            S_PAR:   tx_d = tx_par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_st_q    <= S_IDLE;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_stopn_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_st_q    <= tx_st_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            tx_stopn_q <= tx_stopn_d;
            tx_q       <= tx_d;
        end
    end

    // ---------------- RX FSM ----------------
    state_e      rx_st_q, rx_st_d;
    logic [15:0] rx_tmr_q, rx_tmr_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic        rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        rx_bit_end;

    assign rx_bit_end = (rx_tmr_q == baud_q);

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_tmr_d = rx_tmr_q + 16'd1;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_pen_d = rx_pen_q;
        rx_odd_d = rx_odd_q;
        rx_push  = 1'b0;
        set_perr = 1'b0;
        set_ferr = 1'b0;
        set_ovr  = 1'b0;
        case (rx_st_q)
            S_IDLE: begin
                rx_tmr_d = '0;
                if (ctrl_q[1] && rx_s3_q && !rx_s2_q) begin
                    rx_st_d  = S_START;
                    rx_pen_d = ^ctrl_q[3:2];
                    rx_odd_d = ctrl_q[3];
                end
            end
            S_START: if (rx_tmr_q == (baud_q >> 1)) begin
                rx_tmr_d = '0;
                rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_bit_end) begin
                rx_tmr_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 4'd1;
                if (rx_bit_q == LAST_BIT) rx_st_d = rx_pen_q ? S_PAR : S_STOP;
            end
            S_PAR: if (rx_bit_end) begin
                rx_tmr_d = '0;
                set_perr = (rx_s2_q != ((^rx_sh_q) ^ rx_odd_q));
                rx_st_d  = S_STOP;
            end
            S_STOP: if (rx_bit_end) begin
                rx_tmr_d = '0;
                rx_st_d  = S_IDLE;
                if (!rx_s2_q)                set_ferr = 1'b1;
                else if (rx_full && !rx_pop) set_ovr  = 1'b1;
                else                         rx_push  = 1'b1;
            end
            default: rx_st_d = S_IDLE;
        endcase
        if (!ctrl_q[1]) begin
            rx_st_d  = S_IDLE;
            rx_tmr_d = '0;
            rx_push  = 1'b0;
            set_perr = 1'b0;
            set_ferr = 1'b0;
            set_ovr  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st_q  <= S_IDLE;
            rx_tmr_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
            rx_pen_q <= 1'b0;
            rx_odd_q <= 1'b0;
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rx_s3_q  <= 1'b1;
        end else begin
            rx_st_q  <= rx_st_d;
            rx_tmr_q <= rx_tmr_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
            rx_pen_q <= rx_pen_d;
            rx_odd_q <= rx_odd_d;
            rx_s1_q  <= rx_pin;
            rx_s2_q  <= rx_s1_q;
            rx_s3_q  <= rx_s2_q;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            baud_q <= BAUD_RESET;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= data_i[6:0];
            if (wr_baud) baud_q <= data_i[15:0];
            // A new error in the same cycle as its W1C write is kept.
            perr_q <= set_perr | (perr_q & ~(wr_stat & data_i[3]));
            ferr_q <= set_ferr | (ferr_q & ~(wr_stat & data_i[4]));
            ovr_q  <= set_ovr  | (ovr_q  & ~(wr_stat & data_i[5]));
            irq_q  <= (ctrl_q[5] & ~rx_empty) | (ctrl_q[6] & tx_empty & ~tx_busy);
        end
    end

    always_comb begin
        data_o = '0;
        case (reg_a)
            8'h00: data_o = {25'd0, ctrl_q};
            8'h04: data_o = {25'd0, tx_empty, ovr_q, ferr_q, perr_q, tx_busy, ~rx_empty, tx_full};
            8'h08: data_o = {16'd0, baud_q};
            8'h10: data_o = rx_empty ? 32'd0 : 32'(rx_mem[rx_rp_q]);
            default: data_o = '0;
        endcase
    end

    assign irq_o  = irq_q;
    assign tx_pin = tx_q;
endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: a serial monitor decodes tx_pin against an
// expected-frame queue; register reads are compared with hand-derived values.
`timescale 1ns/1ps
module tb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0, re_i = 1'b0;
    logic [31:0] addr_i = '0, data_i = '0, data_o;
    logic        irq_o, tx_pin, rx_pin;
    logic        loop = 1'b0, rx_drv = 1'b1, mon_en = 1'b1;
    int          bt = 5;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [7:0] d;
        logic       pen;
        logic       par;
        int         nstop;
    } txexp_t;
    txexp_t txq[$];

    assign rx_pin = loop ? tx_pin : rx_drv;

    uart_fifo dut (
        .clk(clk), .rst(rst), .we_i(we_i), .re_i(re_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .irq_o(irq_o), .tx_pin(tx_pin), .rx_pin(rx_pin)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; addr_i = {24'd0, a}; data_i = d;
        @(negedge clk);
        we_i = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr_i = {24'd0, a};
        #1 chk(nm, data_o, exp);
    endtask

    task automatic pop_rx();
        @(negedge clk);
        re_i = 1'b1; addr_i = 32'h10;
        @(negedge clk);
        re_i = 1'b0;
    endtask

    task automatic tx_send(input logic [7:0] d, input logic pen, input logic par, input int nstop);
        txq.push_back('{d: d, pen: pen, par: par, nstop: nstop});
        wr(8'h0C, {24'd0, d});
    endtask

    task automatic wait_tx_done(input string nm);
        int n = 0;
        addr_i = 32'h04;
        do begin
            @(negedge clk);
            #1 n++;
        end while ((txq.size() != 0 || data_o[2]) && n < 3000);
        chk(nm, 32'(n >= 3000), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rx_bit(input logic v);
        @(negedge clk);
        rx_drv = v;
        repeat (bt - 1) @(negedge clk);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic pen, input logic pbit, input logic stopv);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(d[i]);
        if (pen) rx_bit(pbit);
        rx_bit(stopv);
        rx_bit(1'b1);
    endtask

    // One bit time of tx_pin; the bit must hold its value on every sampled cycle.
    task automatic tx_bit(input logic first, output logic val, output logic steady);
        logic s0;
        if (!first) @(negedge clk);
        s0 = tx_pin;
        steady = 1'b1;
        for (int k = 1; k < bt; k++) begin
            @(negedge clk);
            if (tx_pin !== s0) steady = 1'b0;
        end
        val = s0;
    endtask

    initial begin : tx_mon
        txexp_t     e;
        logic       v, st, ok;
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (mon_en && rst === 1'b1 && tx_pin === 1'b0) begin
                if (txq.size() == 0) begin
                    chk("tx_unexpected_frame", 32'd1, 32'd0);
                    for (int w = 0; w < 200 && tx_pin !== 1'b1; w++) @(negedge clk);
                end else begin
                    e  = txq.pop_front();
                    ok = 1'b1;
                    d  = '0;
                    tx_bit(1'b1, v, st); ok &= st;
                    chk("tx_start", 32'(v), 32'd0);
                    for (int i = 0; i < 8; i++) begin
                        tx_bit(1'b0, v, st); ok &= st; d[i] = v;
                    end
                    chk("tx_data", 32'(d), 32'(e.d));
                    if (e.pen) begin
                        tx_bit(1'b0, v, st); ok &= st;
                        chk("tx_parity", 32'(v), 32'(e.par));
                    end
                    for (int s = 0; s < e.nstop; s++) begin
                        tx_bit(1'b0, v, st); ok &= st;
                        chk("tx_stop", 32'(v), 32'd1);
                    end
                    chk("tx_bit_timing", 32'(ok), 32'd1);
                end
            end
        end
    end

    initial begin : stim
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("rst_irq", 32'(irq_o), 32'd0);
        rd_chk("rst_ctrl", 8'h00, 32'h0);
        rd_chk("rst_baud", 8'h08, 32'h01B8);
        rd_chk("rst_status", 8'h04, 32'h40);
        rd_chk("rst_rxdata", 8'h10, 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic TX 8N1
        wr(8'h08, 32'h4); bt = 5;
        rd_chk("baud_rw", 8'h08, 32'h4);
        wr(8'h00, 32'h01);
        tx_send(8'hA5, 1'b0, 1'b0, 1);
        rd_chk("tx_busy_set", 8'h04, 32'h44);
        wait_tx_done("tx_a5_done");
        rd_chk("tx_busy_clear", 8'h04, 32'h40);
        chk("tx_idle_high", 32'(tx_pin), 32'd1);

        // TX-empty interrupt
        wr(8'h00, 32'h41);
        @(negedge clk);
        chk("irq_tx_empty", 32'(irq_o), 32'd1);
        wr(8'h00, 32'h01);
        @(negedge clk);
        chk("irq_tx_empty_off", 32'(irq_o), 32'd0);

        // Parity modes and two stop bits
        wr(8'h00, 32'h05); tx_send(8'h07, 1'b1, 1'b1, 1); wait_tx_done("tx_even_done");
        wr(8'h00, 32'h09); tx_send(8'h07, 1'b1, 1'b0, 1); wait_tx_done("tx_odd_done");
        wr(8'h00, 32'h19); tx_send(8'h07, 1'b1, 1'b0, 2); wait_tx_done("tx_2stop_done");
        wr(8'h00, 32'h0D); tx_send(8'h5A, 1'b0, 1'b0, 1); wait_tx_done("tx_par11_done");

        // Writes dropped while disabled
        wr(8'h00, 32'h00);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); we_i = 1'b1; addr_i = 32'h0C; data_i = 32'(8'hE0 + i);
        end
        @(negedge clk); we_i = 1'b0;
        repeat (3) @(negedge clk);
        rd_chk("tx_disabled_drop", 8'h04, 32'h40);

        // Back-to-back burst: first entry pops at once so 9 fit, 10th is dropped
        wr(8'h00, 32'h01);
        for (int i = 0; i < 9; i++) txq.push_back('{d: 8'(8'h10 + i), pen: 1'b0, par: 1'b0, nstop: 1});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); we_i = 1'b1; addr_i = 32'h0C; data_i = 32'(8'h10 + i);
        end
        @(negedge clk); we_i = 1'b0;
        rd_chk("tx_full_after_burst", 8'h04, 32'h05);
        wait_tx_done("tx_burst_done");

        // Loopback receive with RX interrupt
        loop = 1'b1;
        wr(8'h00, 32'h23);
        tx_send(8'h3C, 1'b0, 1'b0, 1);
        n = 0;
        while (irq_o !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        chk("loop_irq", 32'(irq_o), 32'd1);
        @(negedge clk); addr_i = 32'h04;
        #1 chk("loop_rx_valid", 32'(data_o[1]), 32'd1);
        rd_chk("loop_rxdata", 8'h10, 32'h3C);
        pop_rx();
        wait_tx_done("loop_tx_done");
        rd_chk("loop_after_pop", 8'h04, 32'h40);
        chk("loop_irq_clear", 32'(irq_o), 32'd0);
        loop = 1'b0;

        // False start
        wr(8'h00, 32'h22);
        @(negedge clk); rx_drv = 1'b0;
        repeat (2) @(negedge clk); rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        rd_chk("false_start", 8'h04, 32'h40);

        // Framing error, then W1C
        rx_send(8'h55, 1'b0, 1'b0, 1'b0);
        rd_chk("frame_err_set", 8'h04, 32'h50);
        wr(8'h04, 32'h10);
        rd_chk("frame_err_clear", 8'h04, 32'h40);

        // Parity error (even) keeps the character; then a correct-parity frame
        wr(8'h00, 32'h26);
        rx_send(8'h01, 1'b1, 1'b0, 1'b1);
        rd_chk("parity_err_set", 8'h04, 32'h4A);
        rd_chk("parity_err_data", 8'h10, 32'h01);
        wr(8'h04, 32'h08);
        rd_chk("parity_err_clear", 8'h04, 32'h42);
        pop_rx();
        rx_send(8'h03, 1'b1, 1'b0, 1'b1);
        rd_chk("parity_ok_status", 8'h04, 32'h42);
        rd_chk("parity_ok_data", 8'h10, 32'h03);
        pop_rx();

        // Overrun: 9 frames into an 8-deep FIFO
        wr(8'h00, 32'h22);
        for (int i = 0; i < 9; i++) rx_send(8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
        rd_chk("overrun_status", 8'h04, 32'h62);
        rd_chk("overrun_head", 8'h10, 32'h80);
        chk("overrun_irq", 32'(irq_o), 32'd1);
        pop_rx();
        rd_chk("overrun_next", 8'h10, 32'h81);

        // Asynchronous reset in the middle of a TX frame
        wr(8'h00, 32'h23);
        mon_en = 1'b0;
        wr(8'h0C, 32'h00);
        n = 0;
        while (tx_pin !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        chk("pre_rst_tx_low", 32'(tx_pin), 32'd0);
        chk("pre_rst_irq", 32'(irq_o), 32'd1);
        addr_i = 32'h04;
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("async_rst_irq", 32'(irq_o), 32'd0);
        chk("async_rst_status", data_o, 32'h40);
        addr_i = 32'h10;
        #1 chk("async_rst_rxdata", data_o, 32'h0);
        addr_i = 32'h00;
        #1 chk("async_rst_ctrl", data_o, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
